// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared constants for the load/store access controller
package mem_access_ctrl_pkg;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_MEM  = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [2:0] ALU_ADD = 3'b010;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ALIGN   = 2'd1,
    ERR_OPCODE  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit ALU; add/sub wrap around and discard carry
module alu (
  input  logic [2:0]  alu_ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (alu_ctrl)
      3'b000:  result = a & b;
      3'b001:  result = a | b;
      3'b010:  result = a + b;
      3'b110:  result = a - b;
      3'b111:  result = {31'b0, $signed(a) < $signed(b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/sign_extend.sv
// rtl/sign_extend.sv - 16-bit immediate to 32-bit two's-complement extension
module sign_extend (
  input  logic [15:0] imm,
  output logic [31:0] imm_ext
);

  assign imm_ext = {{16{imm[15]}}, imm};

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequences one lw/sw through address gen, memory handshake and write-back
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        ready,
  input  logic [31:0] instruction,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        reg_write,
  output logic [4:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [4:0]  rt_q, rt_d;
  logic [15:0] imm_q, imm_d;
  logic [31:0] rs_data_q, rs_data_d;
  logic [31:0] rt_data_q, rt_data_d;
  logic [7:0]  wait_q, wait_d;
  logic        ready_q, ready_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  reg_waddr_q, reg_waddr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  err_code_e   err_code_q, err_code_d;

  logic [31:0] imm_ext;
  logic [31:0] addr;
  logic        unused_rs_field;

  assign unused_rs_field = ^instruction[25:21];

  sign_extend u_sign_extend (
    .imm     (imm_q),
    .imm_ext (imm_ext)
  );

  alu u_alu (
    .alu_ctrl (ALU_ADD),
    .a        (rs_data_q),
    .b        (imm_ext),
    .result   (addr)
  );

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    rt_d        = rt_q;
    imm_d       = imm_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    wait_d      = wait_q;
    ready_d     = ready_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    err_code_d  = err_code_q;
    reg_write_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opcode_d   = instruction[31:26];
          rt_d       = instruction[20:16];
          imm_d      = instruction[15:0];
          rs_data_d  = rs_data;
          rt_data_d  = rt_data;
          err_code_d = ERR_NONE;
          ready_d    = 1'b0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // Opcode fault outranks misalignment.
        if (!is_mem_op(opcode_q)) begin
          err_code_d = ERR_OPCODE;
          err_d      = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end else if (addr[1:0] != 2'b00) begin
          err_code_d = ERR_ALIGN;
          err_d      = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end else begin
          mem_addr_d  = addr;
          mem_we_d    = (opcode_q == OP_SW);
          mem_wdata_d = rt_data_q;
          mem_req_d   = 1'b1;
          wait_d      = 8'd0;
          state_d     = ST_MEM;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            reg_waddr_d = rt_q;
            reg_wdata_d = mem_rdata;
            reg_write_d = (rt_q != 5'd0);
            state_d     = ST_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          mem_req_d  = 1'b0;
          err_code_d = ERR_TIMEOUT;
          err_d      = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_WB: begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d   = 1'b1;
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      opcode_q    <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      wait_q      <= '0;
      ready_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      reg_write_q <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      rt_q        <= rt_d;
      imm_q       <= imm_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      wait_q      <= wait_d;
      ready_q     <= ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      reg_write_q <= reg_write_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign ready     = ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign reg_write = reg_write_q;
  assign reg_waddr = reg_waddr_q;
  assign reg_wdata = reg_wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a behavioural memory model
module tb_mem_access_ctrl;

  localparam int TO = 4;
  localparam logic [5:0] LW = 6'h23;
  localparam logic [5:0] SW = 6'h2B;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ready;
  logic [31:0] instruction;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        reg_write;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ready       (ready),
    .instruction (instruction),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .reg_write   (reg_write),
    .reg_waddr   (reg_waddr),
    .reg_wdata   (reg_wdata),
    .done        (done),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          d;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          req_cycles;
  } mem_exp_t;

  typedef struct {
    logic       err;
    logic [1:0] code;
    int         at_cyc;
  } done_exp_t;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_exp_t;

  mem_exp_t  plan_q[$];
  done_exp_t done_q[$];
  wb_exp_t   wb_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: derives every expected response from the instruction rules.
  task automatic issue(input logic [5:0] op, input logic [31:0] rs, input logic [4:0] rt,
                       input logic [15:0] imm, input logic [31:0] wd, input int d,
                       input logic [31:0] rd, input int junk);
    logic [31:0] addr;
    done_exp_t   de;
    mem_exp_t    me;
    wb_exp_t     wbe;
    int          lat;
    int          g;

    g = 0;
    @(negedge clk);
    while (!ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("ready_before_start", {31'b0, ready}, 32'd1);

    addr   = rs + 32'($signed(imm));
    de.err = 1'b1;
    lat    = 2;
    if (op != LW && op != SW) begin
      de.code = 2'd2;
    end else if (addr % 4 != 0) begin
      de.code = 2'd1;
    end else begin
      me.d     = d;
      me.rdata = rd;
      me.addr  = addr;
      me.we    = (op == SW);
      me.wdata = wd;
      if (d >= TO) begin
        me.req_cycles = TO;
        de.code       = 2'd3;
        lat           = TO + 2;
      end else begin
        me.req_cycles = d + 1;
        de.code       = 2'd0;
        de.err        = 1'b0;
        lat           = (op == SW) ? d + 3 : d + 4;
        if (op == LW && rt != 5'd0) begin
          wbe.waddr = rt;
          wbe.wdata = rd;
          wb_q.push_back(wbe);
        end
      end
      plan_q.push_back(me);
    end

    instruction = {op, 5'($urandom), rt, imm};
    rs_data     = rs;
    rt_data     = wd;
    start       = 1'b1;
    @(posedge clk);
    #1;
    de.at_cyc = cyc + lat - 1;
    done_q.push_back(de);

    for (int j = 0; j < junk; j++) begin
      @(negedge clk);
      start       = 1'b1;
      instruction = $urandom;
      rs_data     = $urandom;
      rt_data     = $urandom;
    end
    @(negedge clk);
    start       = 1'b0;
    instruction = $urandom;
    rs_data     = $urandom;
    rt_data     = $urandom;
  endtask

  // Memory responder: acks after the planned wait, checks request stability and length.
  initial begin
    mem_exp_t cur;
    bit       active;
    int       cnt;
    active    = 1'b0;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (reset) begin
        active = 1'b0;
      end else if (mem_req) begin
        if (!active) begin
          if (plan_q.size() == 0) begin
            check("spurious_mem_req", {31'b0, mem_req}, 32'd0);
          end else begin
            cur    = plan_q.pop_front();
            active = 1'b1;
            cnt    = 0;
          end
        end
        if (active) begin
          cnt++;
          check("mem_addr", mem_addr, cur.addr);
          check("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
          if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
          if (cnt - 1 == cur.d) begin
            mem_ack   = 1'b1;
            mem_rdata = cur.rdata;
          end
        end
      end else begin
        if (active) begin
          check("mem_req_cycles", cnt, cur.req_cycles);
          active = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) mem_ack = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (reg_write) begin
        if (wb_q.size() == 0) begin
          check("spurious_reg_write", {31'b0, reg_write}, 32'd0);
        end else begin
          wb_exp_t w;
          w = wb_q.pop_front();
          check("reg_waddr", {27'b0, reg_waddr}, {27'b0, w.waddr});
          check("reg_wdata", reg_wdata, w.wdata);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("spurious_done", {31'b0, done}, 32'd0);
        end else begin
          done_exp_t e;
          e = done_q.pop_front();
          check("err", {31'b0, err}, {31'b0, e.err});
          check("err_code", {30'b0, err_code}, {30'b0, e.code});
          check("done_cycle", cyc, e.at_cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int g;
    reset       = 1'b1;
    start       = 1'b0;
    instruction = '0;
    rs_data     = '0;
    rt_data     = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err_code", {30'b0, err_code}, 32'd0);
    check("rst_reg_write", {31'b0, reg_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    #2 reset = 1'b0;

    issue(SW, 32'h100, 5'd3, 16'hFFFC, 32'hDEADBEEF, 0, 32'h0, 0);
    issue(LW, 32'h2000, 5'd5, 16'h0010, 32'h0, 3, 32'h12345678, 2);
    issue(LW, 32'h1000, 5'd6, 16'h0002, 32'h0, 0, 32'h0, 0);
    issue(6'h00, 32'h1000, 5'd6, 16'h0004, 32'h0, 0, 32'h0, 1);
    issue(6'h00, 32'h1001, 5'd6, 16'h0000, 32'h0, 0, 32'h0, 0);
    issue(LW, 32'h40, 5'd9, 16'h0000, 32'h0, TO + 1, 32'hABCD0000, 0);
    issue(LW, 32'h44, 5'd0, 16'h0000, 32'h0, 1, 32'hCAFEF00D, 0);
    issue(LW, 32'h48, 5'd31, 16'h0000, 32'h0, TO - 1, 32'h0BADCAFE, 2);
    issue(SW, 32'hFFFFFFF0, 5'd1, 16'h0020, 32'h5A5A5A5A, 0, 32'h0, 0);

    issue(LW, 32'h3000, 5'd7, 16'h0000, 32'h0, TO + 3, 32'h0, 0);
    g = 0;
    while (!mem_req && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("mem_req_before_reset", {31'b0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("async_rst_ready", {31'b0, ready}, 32'd1);
    plan_q.delete();
    done_q.delete();
    wb_q.delete();
    repeat (2) @(negedge clk);
    check("rst_hold_done", {31'b0, done}, 32'd0);
    #2 reset = 1'b0;
    issue(LW, 32'h3000, 5'd7, 16'h0008, 32'h0, 0, 32'h77665544, 0);

    for (int i = 0; i < 60; i++) begin
      logic [5:0]  op;
      logic [31:0] rs;
      logic [15:0] imm;
      logic [4:0]  rt;
      int          r;
      r  = $urandom_range(0, 9);
      op = (r < 4) ? LW : (r < 8) ? SW : 6'($urandom);
      if (r >= 8 && (op == LW || op == SW)) op = 6'h00;
      rs  = $urandom;
      imm = 16'($urandom);
      if ($urandom_range(0, 3) != 0) rs[1:0] = 2'd0 - imm[1:0];
      rt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      issue(op, rs, rt, imm, $urandom, $urandom_range(0, TO + 1), $urandom, $urandom_range(0, 2));
    end

    g = 0;
    while ((done_q.size() + plan_q.size() + wb_q.size()) != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("queues_drained", done_q.size() + plan_q.size() + wb_q.size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Multi-cycle controller that sequences one load or store instruction through address generation, a req/ack data-memory handshake and register write-back. It sits between the decode stage and data memory. It reuses the sign_extend block and the ALU in add mode for address generation. It reports completion and faults (misalignment, illegal opcode, memory timeout) to the top-level sequencer.

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req may stay high without mem_ack before the access is aborted (legal range 1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request to execute instruction; sampled only when ready=1
ready  output  1  high in IDLE only
instruction  input  32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:0] imm
rs_data  input  32  base register value, sampled with start
rt_data  input  32  store data, sampled with start
mem_req  output  1  memory access request
mem_we  output  1  1=write (sw), 0=read (lw)
mem_addr  output  32  word-aligned byte address
mem_wdata  output  32  store data
mem_rdata  input  32  load data, valid when mem_ack=1
mem_ack  input  1  memory completion, single-cycle
reg_write  output  1  one-cycle register-file write strobe
reg_waddr  output  5  destination register (rt)
reg_wdata  output  32  load data for write-back
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = faulted
err_code  output  2  0 none, 1 misaligned, 2 illegal opcode, 3 timeout

Behaviour:
- Reset is asynchronous, active-high. While reset is high, state=IDLE, and every output and internal register is 0 except ready=1. Reset mid-access drops mem_req immediately. No write-back or done is produced for the aborted access.
- States: IDLE, ADDR, MEM, WB, DONE.
- IDLE: if start=1 at a clock edge, latch instruction, rs_data and rt_data, then go to ADDR. Start in any other state is ignored (not queued).
- ADDR (1 cycle): addr = rs_data + sign_extend(imm), computed with 32-bit wrap-around and carry discarded. Checks are applied in priority order:
  - opcode not 6'h23 (lw) or 6'h2B (sw): err_code=2, go to DONE.
  - addr[1:0] != 0: err_code=1, go to DONE.
  - otherwise: register mem_addr/mem_we/mem_wdata and go to MEM.
- MEM:
  - mem_req=1; mem_addr, mem_we and mem_wdata are held stable until mem_ack is seen.
  - Wait counter starts at 0 on MEM entry and increments each cycle without ack.
  - Ack and timeout in the same cycle: ack wins.
  - On ack: latch mem_rdata and drop mem_req on the next edge. lw goes to WB; sw goes to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: err_code=3, drop mem_req, go to DONE.
  - mem_ack outside MEM is ignored.
- WB (lw only, 1 cycle): reg_write=1, reg_waddr=rt, reg_wdata=latched data. When rt=0, reg_write stays 0 but the state is still visited, so latency is unchanged.
- DONE (1 cycle): done=1. err=(err_code!=0). err_code is held until the next start is accepted. Then go to IDLE.
- Latency from start edge to done, for ack in the first MEM cycle: sw 3 cycles, lw 4 cycles. Each extra wait cycle adds 1. Fault in ADDR: 2 cycles.
- Registered outputs only; no combinational path from input to output.

Decomposition:
- Shared package: opcode constants (OP_LW=6'h23, OP_SW=6'h2B), state encoding, err_code constants, ALU add control 3'b010.
- Sub-modules: instantiate the existing sign_extend and ALU for address generation. No new sub-module is needed.

Test Plan:
- sw, rs_data=0x100, imm=0xFFFC, rt_data=0xDEADBEEF, ack in first MEM cycle -> mem_addr=0xFC, mem_we=1, mem_wdata=0xDEADBEEF; done 3 cycles after start, err=0, no reg_write.
- lw, rs_data=0x2000, imm=0x0010, rt=5, ack after 3 wait cycles with rdata=0x12345678 -> mem_addr=0x2010, mem_req high 4 cycles; reg_write pulse with waddr=5, wdata=0x12345678; done at cycle 7.
- lw with addr low bits=2'b10 -> no mem_req; done 2 cycles after start, err=1, err_code=1. Opcode 6'h00 -> err_code=2.
- mem_ack never asserted, TIMEOUT_CYCLES=4 -> mem_req high exactly 4 cycles then drops; done with err_code=3. lw to rt=0 -> reg_write never asserted.
- Assert reset asynchronously during MEM -> mem_req drops before the next clock edge; ready=1; no done; a start after reset completes normally.
- start pulses while busy -> ignored; exactly one done per accepted start; stray mem_ack in IDLE -> no effect.
